vram_arb: RTL

- Two-port arbiter in front of the single-port text video RAM (attribute byte plus char byte per word, 13-bit word address).
- Requester A is the terminal writer (char writes and scroll read/write sequences). Requester B is a host/debug port (screen readback, direct pokes).
- Grants RAM ownership by registered round-robin with lock for atomic bursts such as scroll, and a burst cap for unlocked traffic.
- Routes read data back to the issuing requester with a fixed latency.

---
 rtl/vram_pkg.sv | 20 ++
 rtl/vram_arb_rdroute.sv | 79 +++++++
 rtl/vram_arb.sv | 132 +++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared types and constants for the text video RAM arbiter slice.
package vram_pkg;

  localparam int         ADR_W_DEF  = 13;
  localparam int         DAT_W_DEF  = 16;
  localparam int         SCR_STRIDE = 128;
  localparam logic [7:0] ATTR_DEF   = 8'h1F;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } own_state_t;

  typedef logic req_id_t;

  localparam req_id_t ID_A = 1'b0;
  localparam req_id_t ID_B = 1'b1;

endpackage

// File: rtl/vram_arb_rdroute.sv
// Read-return path: carries the issuer tag alongside the RAM read latency and
// steers rvalid to that requester. LAT=2 adds a register on ram_q.
module vram_arb_rdroute
  import vram_pkg::*;
#(
  parameter int DAT_W = DAT_W_DEF,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_vld_p0,
  input  req_id_t          rd_id_p0,
  input  logic [DAT_W-1:0] ram_q,
  output logic             a_rvalid,
  output logic [DAT_W-1:0] a_rdata,
  output logic             b_rvalid,
  output logic [DAT_W-1:0] b_rdata
);

  logic             rvld;
  req_id_t          rid;
  logic [DAT_W-1:0] rdat;

  generate
    if (LAT == 2) begin : g_lat2
      logic             vld_p1;
      logic             vld_p2;
      req_id_t          id_p1;
      req_id_t          id_p2;
      logic [DAT_W-1:0] q_p2;

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_p1 <= 1'b0;
          vld_p2 <= 1'b0;
          id_p1  <= ID_A;
          id_p2  <= ID_A;
        end else begin
          vld_p1 <= rd_vld_p0;
          vld_p2 <= vld_p1;
          id_p1  <= rd_id_p0;
          id_p2  <= id_p1;
        end
      end

      // stage p2: RAM output captured locally to ease timing into requesters
      always_ff @(posedge clk) begin
        q_p2 <= ram_q;
      end

      assign rvld = vld_p2;
      assign rid  = id_p2;
      assign rdat = q_p2;
    end else begin : g_lat1
      logic    vld_p1;
      req_id_t id_p1;

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_p1 <= 1'b0;
          id_p1  <= ID_A;
        end else begin
          vld_p1 <= rd_vld_p0;
          id_p1  <= rd_id_p0;
        end
      end

      assign rvld = vld_p1;
      assign rid  = id_p1;
      assign rdat = ram_q;
    end
  endgenerate

  assign a_rvalid = rvld && (rid == ID_A);
  assign b_rvalid = rvld && (rid == ID_B);
  assign a_rdata  = rdat;
  assign b_rdata  = rdat;

endmodule

// File: rtl/vram_arb.sv
// Two-port round-robin arbiter with owner lock and burst cap for the text VRAM.
// Define VRAM_ARB_RDREG_EN to register ram_q internally (read latency 2).
module vram_arb
  import vram_pkg::*;
#(
  parameter int ADR_W     = ADR_W_DEF,
  parameter int DAT_W     = DAT_W_DEF,
  parameter int MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_req,
  input  logic             a_lock,
  input  logic             a_we,
  input  logic [ADR_W-1:0] a_adr,
  input  logic [DAT_W-1:0] a_wdata,
  output logic             a_gnt,
  output logic             a_rvalid,
  output logic [DAT_W-1:0] a_rdata,
  input  logic             b_req,
  input  logic             b_lock,
  input  logic             b_we,
  input  logic [ADR_W-1:0] b_adr,
  input  logic [DAT_W-1:0] b_wdata,
  output logic             b_gnt,
  output logic             b_rvalid,
  output logic [DAT_W-1:0] b_rdata,
  output logic [ADR_W-1:0] ram_adr,
  output logic [DAT_W-1:0] ram_wdata,
  output logic             ram_wr,
  input  logic [DAT_W-1:0] ram_q
);

`ifdef VRAM_ARB_RDREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  own_state_t state, state_nxt;
  req_id_t    rr, rr_nxt;
  logic [7:0] burst_cnt, burst_nxt;

  logic a_iss, b_iss;
  logic own_req, own_lock, own_iss, oth_req;
  logic sel_b;
  logic rd_vld_p0;
  req_id_t rd_id_p0;

  assign a_gnt = (state == OWN_A);
  assign b_gnt = (state == OWN_B);
  assign a_iss = a_gnt && a_req;
  assign b_iss = b_gnt && b_req;

  assign own_req  = b_gnt ? b_req  : a_req;
  assign own_lock = b_gnt ? b_lock : a_lock;
  assign own_iss  = a_iss || b_iss;
  assign oth_req  = b_gnt ? a_req  : b_req;

  always_comb begin
    state_nxt = state;
    unique case (state)
      OWN_IDLE: begin
        if (a_req && b_req) state_nxt = (rr == ID_A) ? OWN_B : OWN_A;
        else if (a_req)     state_nxt = OWN_A;
        else if (b_req)     state_nxt = OWN_B;
      end
      OWN_A, OWN_B: begin
        // a locked owner keeps the RAM even through idle cycles
        if (!own_lock &&
            (!own_req || (oth_req && own_iss && (burst_cnt == BURST_LAST)))) begin
          if (oth_req) state_nxt = (state == OWN_A) ? OWN_B : OWN_A;
          else         state_nxt = OWN_IDLE;
        end
      end
      default: state_nxt = OWN_IDLE;
    endcase
  end

  always_comb begin
    burst_nxt = burst_cnt;
    if (state_nxt != state)
      burst_nxt = 8'd0;
    else if (own_iss && !own_lock && (burst_cnt != BURST_LAST))
      burst_nxt = burst_cnt + 8'd1;
  end

  always_comb begin
    rr_nxt = rr;
    if ((state_nxt == OWN_A) && (state != OWN_A)) rr_nxt = ID_A;
    if ((state_nxt == OWN_B) && (state != OWN_B)) rr_nxt = ID_B;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= OWN_IDLE;
      rr        <= ID_B;
      burst_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      rr        <= rr_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // stage p0: RAM request muxed from the owner, or the last owner while idle
  assign sel_b     = b_gnt || ((state == OWN_IDLE) && (rr == ID_B));
  assign ram_adr   = sel_b ? b_adr   : a_adr;
  assign ram_wdata = sel_b ? b_wdata : a_wdata;
  assign ram_wr    = (a_iss && a_we) || (b_iss && b_we);

  assign rd_vld_p0 = (a_iss && !a_we) || (b_iss && !b_we);
  assign rd_id_p0  = b_iss ? ID_B : ID_A;

  vram_arb_rdroute #(
    .DAT_W (DAT_W),
    .LAT   (RD_LAT)
  ) u_rdroute (
    .clk       (clk),
    .reset     (reset),
    .rd_vld_p0 (rd_vld_p0),
    .rd_id_p0  (rd_id_p0),
    .ram_q     (ram_q),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata)
  );

endmodule
